// File: rtl/de2_pio_button_in.sv
// rtl/de2_pio_button_in.sv - debounced button/switch PIO with edge capture and level irq
module de2_pio_button_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] deb, deb_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [WIDTH-1:0] wdata;
  logic             wr;

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  // Synchronizer, debounce counters and delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise     = deb & ~deb_d;
  assign fall     = ~deb & deb_d;
  assign edge_det = (EDGE_TYPE == 0) ? fall :
                    (EDGE_TYPE == 1) ? rise : (rise | fall);

  // A newly detected edge wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr && address == 2'd2) irqmask <= wdata;
      if (wr && address == 2'd3) edgecapture <= (edgecapture & ~wdata) | edge_det;
      else                       edgecapture <= edgecapture | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(deb);
        2'd2:    readdata <= 32'(irqmask);
        2'd3:    readdata <= 32'(edgecapture);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_de2_pio_button_in.sv
// tb/tb_de2_pio_button_in.sv - scoreboard bench for de2_pio_button_in
module tb_de2_pio_button_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  de2_pio_button_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, readdata, e.val);
    end
  endtask

  // All tasks enter and leave on a falling edge
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address = a;
    expect_push(tag, exp);
    @(negedge clk);
    sb_pop();
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'h0;
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    bus_read(2'd2, "rst_irqmask", 32'h0);
    bus_read(2'd3, "rst_edgecap", 32'h0);

    // Register map: width truncation and reserved address
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, "irqmask_trunc", 32'h0000_000F);
    bus_write(2'd1, 32'hDEAD_BEEF);
    bus_read(2'd1, "reserved_zero", 32'h0);

    // Clean step on bit0: exact debounce latency and falling capture
    bus_write(2'd2, 32'h1);
    in_port = 4'h1;
    wait_cycles(20);
    bus_read(2'd0, "bit0_high", 32'h1);
    bus_read(2'd3, "rise_ignored", 32'h0);
    address = 2'd0;
    in_port = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      expect_push($sformatf("fall_lat_%0d", k), (k <= 6) ? 32'h1 : 32'h0);
      @(negedge clk);
      sb_pop();
      check($sformatf("irq_lat_%0d", k), 32'(irq), 32'(k >= 7));
    end
    bus_read(2'd3, "edgecap_bit0", 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_after_clr", 32'(irq), 32'h0);

    // Short glitch on bit1 must be rejected
    bus_write(2'd2, 32'hF);
    in_port = 4'h2;
    wait_cycles(20);
    bus_read(2'd3, "glitch_pre_cap", 32'h0);
    in_port = 4'h0;
    wait_cycles(3);
    in_port = 4'h2;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("glitch_irq_%0d", k), 32'(irq), 32'h0);
    end
    bus_read(2'd0, "glitch_data", 32'h2);
    bus_read(2'd3, "glitch_edgecap", 32'h0);

    // Selective write-1-to-clear
    in_port = 4'h3;
    wait_cycles(20);
    in_port = 4'h0;
    wait_cycles(20);
    bus_read(2'd3, "edgecap_3", 32'h3);
    check("irq_ec3", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_after_clr1", 32'(irq), 32'h1);
    bus_read(2'd3, "edgecap_after_clr1", 32'h2);
    bus_write(2'd3, 32'h2);
    check("irq_after_clr2", 32'(irq), 32'h0);
    bus_read(2'd3, "edgecap_after_clr2", 32'h0);

    // Clear in the same cycle the edge is captured: set wins
    in_port = 4'h1;
    wait_cycles(20);
    bus_read(2'd3, "same_cyc_pre", 32'h0);
    in_port = 4'h0;
    wait_cycles(6);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, "set_wins", 32'h1);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, "write0_keeps", 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, "clr_after_set", 32'h0);

    // Asynchronous reset with pending interrupts
    in_port = 4'hF;
    wait_cycles(20);
    in_port = 4'h0;
    wait_cycles(20);
    bus_read(2'd3, "edgecap_F", 32'hF);
    check("irq_F", 32'(irq), 32'h1);
    in_port = 4'hF;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, "post_rst_irqmask", 32'h0);
    bus_read(2'd3, "post_rst_edgecap", 32'h0);
    wait_cycles(20);
    bus_read(2'd0, "held_high_data", 32'hF);
    bus_read(2'd3, "held_high_nocap", 32'h0);

    // Reset in the middle of a debounce count
    in_port = 4'h0;
    wait_cycles(4);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(20);
    bus_read(2'd3, "mid_deb_nocap", 32'h0);
    bus_read(2'd0, "mid_deb_data", 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/de2_pio_button_in.md
DE2_PIO_BUTTON_IN -- requirements
Module: de2_pio_button_in

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of input bits.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000, stable-cycle count needed to accept a new level; legal range 1..2^20.
REQ-003 SHALL provide parameter EDGE_TYPE, default 0; 0 = falling, 1 = rising, 2 = any edge.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous button/switch inputs.
REQ-011 readdata  output  32  read data, read latency 1.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep per bit a debounced level and a counter; counter clears whenever the synchronized bit equals the debounced level.
REQ-015 SHALL increment the counter each cycle the synchronized bit differs from the debounced level; on reaching DEBOUNCE_CYCLES-1 the debounced bit takes the synchronized value and the counter clears the same cycle.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL not change the debounced level; a bounce resets the count to 0.
REQ-017 Latency in_port change to debounced change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step.
REQ-018 SHALL detect edges by comparing debounced level with its one-cycle-delayed copy, per EDGE_TYPE.
REQ-019 Register map: 0 data (RO, debounced level); 1 reserved (reads 0, writes ignored); 2 irqmask (RW, WIDTH bits); 3 edgecapture (R, write-1-to-clear).
REQ-020 A write SHALL occur when chipselect=1 and write_n=0 at a rising clk edge; writedata bits above WIDTH-1 ignored.
REQ-021 edgecapture bit SHALL set on detected edge and hold until cleared by writing 1 to that bit at address 3.
REQ-022 Same-cycle edge detect and clear on one bit: set SHALL win (bit remains 1).
REQ-023 Writes of 0 to edgecapture bits SHALL leave them unchanged.
REQ-024 readdata SHALL register every cycle the mux of the current address, zero-extended to 32 bits; valid the cycle after address presented, independent of chipselect.
REQ-025 irq SHALL be combinational OR of (edgecapture AND irqmask), no added latency.
REQ-026 Writing irqmask SHALL affect irq in the cycle after the write edge.

Reset
REQ-027 On reset_n=0, immediately and regardless of clk: synchronizer flops, debounced levels and delayed copies SHALL be 0; counters 0; irqmask 0; edgecapture 0; readdata 0; irq 0.
REQ-028 Release of reset SHALL not create a spurious edge; if in_port is held 1 through reset, the resulting 0->1 debounced transition IS a rising edge and SHALL be captured per EDGE_TYPE.
REQ-029 Reset asserted mid-debounce SHALL abandon the count; no edgecapture bit set.

Verification
REQ-030 DEBOUNCE_CYCLES=4, EDGE_TYPE=0: in_port[0] 1 for 20 cycles then 0 -> data bit0 goes 0 exactly 6 cycles after the fall; edgecapture=0x1; with irqmask=0x1 irq=1.
REQ-031 in_port[1] toggles 1->0 for 3 cycles then back (DEBOUNCE_CYCLES=4) -> data unchanged, edgecapture stays 0, irq stays 0.
REQ-032 edgecapture=0x3, irqmask=0xF; write 0x1 to address 3 -> edgecapture=0x2, irq stays 1; write 0x2 -> edgecapture=0, irq=0 next cycle.
REQ-033 Write clear 0x1 to address 3 in the same cycle bit0 edge is detected -> edgecapture bit0 remains 1.
REQ-034 Write 0xFFFFFFFF to address 2, read address 2 -> readdata=0x0000000F; read address 1 -> 0x00000000.
REQ-035 Assert reset_n=0 between clk edges with edgecapture=0xF, irq=1 -> irq, readdata, irqmask, edgecapture 0 immediately.
